credit_rx: RTL and testbench
============================

Name: credit_rx

Overview:
- Receiver end of a credit-based point-to-point link. The transmitter pushes payload with valid only; there is no ready.
- Payload lands in a DEPTH-entry buffer and is re-presented on a standard valid/ready master port.
- One credit returns to the transmitter per popped entry. After reset, DEPTH initial credits are granted.
- Used to cross long or pipelined channels where a combinational ready path cannot be closed. Typically placed at the far end of a chain of valid-only pipe stages.

Parameters:
- PLD_TYPE, logic, payload type.
- DEPTH, 4, buffer entries and total credits in the loop; DEPTH >= 1, any integer (not only powers of 2).
- NO_DATA_RESET, 1'b0, when 1 the payload storage has no reset.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- s_pld  input  $bits(PLD_TYPE)  inbound payload.
- s_vld  input  1  inbound beat valid; no backpressure.
- crd_rtn  output  1  one-cycle pulse = one credit returned to transmitter.
- m_pld  output  $bits(PLD_TYPE)  outbound payload.
- m_vld  output  1  outbound valid.
- m_rdy  input  1  outbound ready.
- ovf_err  output  1  sticky overflow error flag.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - m_vld=0, crd_rtn=0, ovf_err=0.
  - m_pld=0, unless NO_DATA_RESET=1, in which case it is undefined.
  - Internal: wr_ptr=0, rd_ptr=0, occupancy=0, owed=DEPTH, rst_lock_n=0.
- rst_lock_n: flop, 0 in reset, 1 from the first clk edge after deassert.
  - While 0: push ignored, crd_rtn forced 0.
- Push:
  - push = s_vld && rst_lock_n.
  - Writes entry[wr_ptr]; wr_ptr wraps DEPTH-1 -> 0.
- Pop:
  - pop = m_vld && m_rdy.
  - rd_ptr advances with the same wrap rule.
- Output port:
  - m_vld = (occupancy != 0); m_pld = entry[rd_ptr]. Both come from registers, with no combinational path from s_*.
  - Push at edge t -> m_vld=1 after edge t (1-cycle latency).
  - Sustained throughput: 1 beat/cycle when m_rdy=1.
- Occupancy:
  - occupancy_next = occupancy + push_acc - pop.
  - Width $clog2(DEPTH+1).
- Full and overflow:
  - full = (occupancy == DEPTH).
  - push && full && !pop: beat dropped, pointers and occupancy unchanged, ovf_err <= 1. ovf_err stays 1 until reset.
  - push && full && pop: accepted normally.
- Empty:
  - Simultaneous push and pop while empty is impossible, because m_vld=0.
  - The pushed beat appears the next cycle.
- Credit return:
  - owed counter, width $clog2(DEPTH+1).
  - crd_rtn = (owed != 0) && rst_lock_n. Driven from registers only.
  - owed_next = owed + pop - crd_rtn.
  - Consequently, DEPTH initial pulses occur on consecutive cycles starting the first cycle after the reset lock releases.
  - Each pop produces one pulse, at earliest the next cycle. Pulses queue if owed > 0.
- Invariant: owed + occupancy + credits/beats held by the transmitter or in flight == DEPTH. Therefore owed <= DEPTH, and it never overflows under legal traffic.
- Reset mid-operation: all state returns to reset values asynchronously. Buffered beats are lost, and DEPTH credits are re-granted after release. The transmitter must be reset in the same domain.

Decomposition:
- Shared package: typedef for the credit count width (function of DEPTH) and a credit link interface struct {pld, vld}, reused by the matching credit_tx.
- One natural sub-module: credit_rx_buf, a DEPTH-entry circular buffer with push/pop/full/occupancy and a NO_DATA_RESET option.
- credit_rx itself holds the reset lock, the owed counter and ovf_err.

Test Plan:
- Reset release, DEPTH=4, no traffic -> crd_rtn high exactly cycles 1..4 after release, then 0; m_vld=0; ovf_err=0.
- Single beat 0xA5 pushed, m_rdy=1 -> m_vld=1 with m_pld=0xA5 the next cycle. The pop occurs that cycle, and crd_rtn pulses once the following cycle.
- 16 back-to-back beats 0..15, m_rdy=1, transmitter honoring credits -> output 0..15 in order at 1 beat/cycle after the initial latency. Exactly 16 crd_rtn pulses after the initial 4.
- m_rdy=0, push 4 beats -> occupancy 4, no crd_rtn. Release m_rdy -> 4 pops on consecutive cycles, then 4 crd_rtn pulses; pointer wrap verified with DEPTH=3 as well.
- Full plus a 5th push with m_rdy=0 -> beat dropped, ovf_err=1 and sticky; a push on the same cycle as a pop while full is accepted without error.
- Reset asserted with 2 entries buffered and owed=1 -> m_vld=0, ovf_err=0 immediately. After release, exactly DEPTH pulses, and old data is never presented.

Source files
------------

// File: rtl/credit_rx_pkg.sv
// Shared types and width helpers for the credit link (receiver and transmitter ends).
package credit_rx_pkg;

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_PLD_W = 8;

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [$clog2(DEF_DEPTH+1)-1:0] crd_cnt_t;

    typedef struct packed {
        logic [DEF_PLD_W-1:0] pld;
        logic                 vld;
    } crd_link_t;

endpackage

// File: rtl/credit_rx_buf.sv
// DEPTH-entry circular buffer; any DEPTH >= 1, wrap at DEPTH-1.
module credit_rx_buf
    import credit_rx_pkg::*;
#(
    parameter type         PLD_TYPE      = logic,
    parameter int unsigned DEPTH         = 4,
    parameter bit          NO_DATA_RESET = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  PLD_TYPE wr_pld,
    output PLD_TYPE rd_pld,
    output logic    not_empty,
    output logic    full
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occ;
    logic             wr_en;
    PLD_TYPE          mem [DEPTH];

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is taken only when a pop frees a slot the same cycle.
    assign wr_en     = push && (!full || pop);
    assign full      = (occ == CNT_W'(DEPTH));
    assign not_empty = (occ != '0);
    assign rd_pld    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= nxt(wr_ptr);
            if (pop)   rd_ptr <= nxt(rd_ptr);
            occ <= occ + CNT_W'(wr_en) - CNT_W'(pop);
        end
    end

    if (NO_DATA_RESET) begin : g_nrst
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= wr_pld;
        end
    end else begin : g_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_en) begin
                mem[wr_ptr] <= wr_pld;
            end
        end
    end

endmodule

// File: rtl/credit_rx.sv
// Credit-based link receiver: buffers valid-only beats, re-presents them valid/ready,
// returns one credit per pop and grants DEPTH credits after reset.
module credit_rx
    import credit_rx_pkg::*;
#(
    parameter type         PLD_TYPE      = logic,
    parameter int unsigned DEPTH         = 4,
    parameter bit          NO_DATA_RESET = 1'b0
) (
    input  logic    clk,
    input  logic    rst_n,
    input  PLD_TYPE s_pld,
    input  logic    s_vld,
    output logic    crd_rtn,
    output PLD_TYPE m_pld,
    output logic    m_vld,
    input  logic    m_rdy,
    output logic    ovf_err
);

    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic             rst_lock_n;
    logic [CNT_W-1:0] owed;
    logic             push;
    logic             pop;
    logic             full;

    assign push    = s_vld && rst_lock_n;
    assign pop     = m_vld && m_rdy;
    assign crd_rtn = (owed != '0) && rst_lock_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_lock_n <= 1'b0;
            owed       <= CNT_W'(DEPTH);
            ovf_err    <= 1'b0;
        end else begin
            rst_lock_n <= 1'b1;
            owed       <= owed + CNT_W'(pop) - CNT_W'(crd_rtn);
            if (push && full && !pop) ovf_err <= 1'b1;
        end
    end

    credit_rx_buf #(
        .PLD_TYPE      (PLD_TYPE),
        .DEPTH         (DEPTH),
        .NO_DATA_RESET (NO_DATA_RESET)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wr_pld    (s_pld),
        .rd_pld    (m_pld),
        .not_empty (m_vld),
        .full      (full)
    );

endmodule

// File: tb/tb_credit_rx.sv
// Self-checking bench for credit_rx at DEPTH=4 and DEPTH=3 against a shift-queue model.
module tb_credit_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_vld   [2];
    logic [7:0] s_pld   [2];
    logic       m_rdy   [2];
    logic       crd_rtn [2];
    logic [7:0] m_pld   [2];
    logic       m_vld   [2];
    logic       ovf_err [2];

    int n_pass = 0;
    int n_chk  = 0;

    // reference model: front of each queue is index 0
    logic [7:0] mq   [2][16];
    int         mcnt [2];
    int         owed [2];
    int         txc  [2];
    bit         ovf  [2];
    bit         lock;

    always #5 clk = ~clk;

    credit_rx #(.PLD_TYPE(logic [7:0]), .DEPTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .s_pld(s_pld[0]), .s_vld(s_vld[0]), .crd_rtn(crd_rtn[0]),
        .m_pld(m_pld[0]), .m_vld(m_vld[0]), .m_rdy(m_rdy[0]), .ovf_err(ovf_err[0])
    );

    credit_rx #(.PLD_TYPE(logic [7:0]), .DEPTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .s_pld(s_pld[1]), .s_vld(s_vld[1]), .crd_rtn(crd_rtn[1]),
        .m_pld(m_pld[1]), .m_vld(m_vld[1]), .m_rdy(m_rdy[1]), .ovf_err(ovf_err[1])
    );

    function automatic int dep(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic ck(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s inst%0d got=%h exp=%h", tag, i, got, exp);
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            ck({tag, ".m_vld"}, i, 8'(m_vld[i]), 8'(mcnt[i] != 0));
            if (mcnt[i] != 0) ck({tag, ".m_pld"}, i, m_pld[i], mq[i][0]);
            ck({tag, ".crd"}, i, 8'(crd_rtn[i]), 8'((owed[i] != 0) && lock));
            ck({tag, ".ovf"}, i, 8'(ovf_err[i]), 8'(ovf[i]));
        end
    endtask

    task automatic model_reset();
        lock = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0;
            owed[i] = dep(i);
            txc[i]  = 0;
            ovf[i]  = 1'b0;
        end
    endtask

    task automatic step(input string tag);
        bit crd, pop, push, full;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            crd  = (owed[i] != 0) && lock;
            pop  = (mcnt[i] != 0) && m_rdy[i];
            push = s_vld[i] && lock;
            full = (mcnt[i] == dep(i));
            if (push && full && !pop) ovf[i] = 1'b1;
            if (pop) begin
                for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
                mcnt[i]--;
            end
            if (push && (!full || pop)) begin
                mq[i][mcnt[i]] = s_pld[i];
                mcnt[i]++;
            end
            owed[i] = owed[i] + int'(pop) - int'(crd);
            txc[i]  = txc[i] + int'(crd) - int'(s_vld[i]);
        end
        lock = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic r);
        for (int i = 0; i < 2; i++) begin
            s_vld[i] = v;
            m_rdy[i] = r;
        end
    endtask

    task automatic idle(input int n, input string tag);
        drive(1'b0, 1'b1);
        for (int c = 0; c < n; c++) step(tag);
    endtask

    initial begin
        int sent [2];
        rst_n = 1'b0;
        drive(1'b0, 1'b0);
        s_pld[0] = '0;
        s_pld[1] = '0;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) ck("rst.m_pld", i, m_pld[i], 8'h00);
        check_all("rst");
        #5 rst_n = 1'b1;
        idle(6, "grant");

        // single beat
        drive(1'b1, 1'b1);
        s_pld[0] = 8'hA5;
        s_pld[1] = 8'hA5;
        step("single");
        idle(4, "single");

        // 16 beats honoring credits
        sent[0] = 0;
        sent[1] = 0;
        for (int c = 0; c < 100 && (sent[0] < 16 || sent[1] < 16); c++) begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] = 1'b1;
                s_vld[i] = (txc[i] > 0) && (sent[i] < 16);
                s_pld[i] = 8'(sent[i]);
                if (s_vld[i]) sent[i]++;
            end
            step("stream");
        end
        for (int i = 0; i < 2; i++) ck("stream.sent", i, 8'(sent[i]), 8'd16);
        idle(8, "stream");

        // stall with m_rdy=0, fill, then drain (wraps pointers)
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] = 1'b0;
                s_vld[i] = (b < dep(i));
                s_pld[i] = 8'(8'h40 + b + 16 * i);
            end
            step("stall");
        end
        idle(10, "drain");

        // fill, push+pop while full (accepted), then push while full (dropped)
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i] = 1'b0;
                s_vld[i] = (b < dep(i));
                s_pld[i] = 8'(8'h80 + b);
            end
            step("fill");
        end
        drive(1'b1, 1'b1);
        s_pld[0] = 8'hC1;
        s_pld[1] = 8'hC1;
        step("full_pp");
        drive(1'b1, 1'b0);
        s_pld[0] = 8'hEE;
        s_pld[1] = 8'hEE;
        step("ovf");
        drive(1'b0, 1'b0);
        step("ovf_sticky");
        idle(10, "ovf_drain");

        // mid-operation reset with 2 entries buffered and owed=1
        drive(1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            s_pld[0] = 8'(8'h60 + b);
            s_pld[1] = 8'(8'h70 + b);
            step("pre_rst");
        end
        drive(1'b0, 1'b1);
        step("pre_rst_pop");
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) ck("midrst.m_pld", i, m_pld[i], 8'h00);
        check_all("midrst");
        #2 rst_n = 1'b1;
        idle(6, "regrant");

        // randomized credit-honoring traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                s_vld[i] = (txc[i] > 0) && ($urandom_range(0, 3) != 0);
                s_pld[i] = 8'($urandom);
                m_rdy[i] = ($urandom_range(0, 2) != 0);
            end
            step("rand");
        end
        idle(10, "final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
